axi_req_arbiter: RTL and testbench
==================================

# axi_req_arbiter

Round-robin arbiter that shares the single `axi_master` read/write control port between `NUM_REQ` requesters, e.g. instruction fetch and load/store in the popo RISC-V core. It grants one burst at a time and holds `start_read`/`start_write` with the latched address and length until the master's `done_read`/`done_write`. It returns a one-cycle completion pulse to the winner, routes the write-data FIFO signals to it, and aborts any burst with an error after a watchdog timeout.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `BURST_LEN_WIDTH`, 8: width of the burst-length field, AXI-encoded as beats-1.
- `DATA_WIDTH`, 32: write-data width.
- `TIMEOUT_CYC`, 1024: maximum number of BUSY cycles before abort; must be at least 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NUM_REQ: request pending, one bit per requester.
- `req_write`, in, NUM_REQ: 1 = write burst, 0 = read burst.
- `req_addr`, in, NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_len`, in, NUM_REQ*BURST_LEN_WIDTH: packed lengths, beats-1.
- `req_wdata`, in, NUM_REQ*DATA_WIDTH: packed write-FIFO head data.
- `req_wfifo_empty`, in, NUM_REQ: write FIFO empty flags.
- `req_wfifo_pull`, out, NUM_REQ: write FIFO pop, routed to the winner only.
- `req_gnt`, out, NUM_REQ: one-hot grant pulse, one cycle.
- `req_done`, out, NUM_REQ: one-hot completion pulse, one cycle.
- `req_err`, out, NUM_REQ: timeout flag, pulsed together with `req_done`.
- `start_read`, out, 1: to master.
- `target_read_addr`, out, ADDR_WIDTH: to master.
- `target_read_burst_len`, out, BURST_LEN_WIDTH: to master.
- `done_read`, in, 1: from master.
- `start_write`, out, 1: to master.
- `target_write_addr`, out, ADDR_WIDTH: to master.
- `target_write_burst_len`, out, BURST_LEN_WIDTH: to master.
- `target_write_data`, out, DATA_WIDTH: to master.
- `target_write_fifo_empty`, out, 1: to master.
- `target_write_fifo_pull`, in, 1: from master.
- `done_write`, in, 1: from master.

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE:
  - If any `req_valid` bit is set, select the winner: the first set bit searching upward from `rr_ptr`, wrapping mod NUM_REQ.
  - At the clock edge: latch winner index, dir (`req_write`), addr and len; set `req_gnt[win]`=1; set `start_read` if dir=0, else `start_write`; clear the timeout counter; go to BUSY.
  - If no `req_valid` bit is set, stay in IDLE.
- BUSY:
  - Hold `start_*` and `target_*_addr/len` constant from the latched values.
  - Count cycles; the counter width is $clog2(TIMEOUT_CYC)+1.
  - Only the done matching the latched dir completes the burst (`done_read` when dir=0, `done_write` when dir=1). The other done is ignored.
  - On the matching done: drop `start_*`, pulse `req_done[win]`, set `rr_ptr` = (win+1) mod NUM_REQ, go to GAP.
  - Timeout: if the counter reaches TIMEOUT_CYC-1 with no matching done, drop `start_*`, pulse both `req_done[win]` and `req_err[win]`, advance `rr_ptr` as on completion, go to GAP.
- GAP: `start_*` stay low for exactly one cycle, then go to IDLE. This guarantees the master sees a start deassertion between bursts.
- Write-data routing (combinational):
  - In BUSY with dir=1: `target_write_data` = `req_wdata[win]`, `target_write_fifo_empty` = `req_wfifo_empty[win]`, `req_wfifo_pull[win]` = `target_write_fifo_pull`.
  - In all other cases: `target_write_fifo_empty`=1, `target_write_data`=0, all `req_wfifo_pull`=0.
- Requester contract:
  - Hold `req_valid`, `req_write`, `req_addr`, `req_len` stable until `req_gnt` is seen.
  - Drop `req_valid` in the cycle after `req_gnt` or after `req_done`; `req_valid` still high in IDLE is treated as a new request.
  - `req_valid` changes while not granted may be ignored.
- `target_*_addr/len` read 0 when their start is low.

## Timing
- Reset (async, immediate, also mid-burst): state=IDLE, `rr_ptr`=0, counter=0. All outputs are 0 except `target_write_fifo_empty`=1. An in-flight burst is abandoned silently, with no `req_done`.
- Request to start latency: `req_valid` sampled high at edge N → `start_*` and `req_gnt` high from N until N+1. `req_gnt` lasts one cycle; `start_*` remains high.
- Done to completion: matching done sampled high at edge M → `req_done` high for the cycle after M, and `start_*` low from M.
- Back-to-back: the next grant is at edge M+2 at the earliest, giving a minimum of 3 cycles per single-beat turnaround overhead.
- Simultaneous requests are granted in round-robin order; with all requesters always requesting, grants rotate 0,1,…,NUM_REQ-1,0.
- A done asserted in IDLE or GAP is ignored.
- Timeout: `req_err` pulses exactly TIMEOUT_CYC cycles after the grant edge.

## Test plan
- Single read: req0 reads addr=123, len=3; the master returns `done_read` 6 cycles later → `start_read` is high with `target_read_addr`=123 and `target_read_burst_len`=3 until done; `req_done[0]` pulses once; `req_err`=0.
- Contention: req0 and req1 both valid at the same edge, `rr_ptr`=0 → req0 is granted first, then req1 after GAP; with both held asserted, the grant sequence is 0,1,0,1.
- Write routing: req1 writes addr=5, len=0; its FIFO holds 32'hDEADBEEF → `target_write_data`=32'hDEADBEEF; a `target_write_fifo_pull` pulse appears on `req_wfifo_pull[1]` only; `req_done[1]` pulses after `done_write`.
- Wrong done ignored: a read is in flight and `done_write` pulses → no completion; the later `done_read` completes the burst normally.
- Timeout: TIMEOUT_CYC=16, the master never responds → `start_read` drops and `req_done[0]` and `req_err[0]` pulse together 16 cycles after the grant; the next request is then granted normally.
- Reset mid-burst: `rst` is asserted during BUSY → all starts, grants and dones go to 0 immediately; after release, a new req1 request is granted first with `rr_ptr`=0 semantics.

Source files
------------

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI master read/write control port between
// NUM_REQ requesters; one burst at a time, watchdog abort on a stuck master.
module axi_req_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYC     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BURST_LEN_WIDTH-1:0] req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]              req_wfifo_empty,
  output logic [NUM_REQ-1:0]              req_wfifo_pull,
  output logic [NUM_REQ-1:0]              req_gnt,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [NUM_REQ-1:0]              req_err,
  output logic                            start_read,
  output logic [ADDR_WIDTH-1:0]           target_read_addr,
  output logic [BURST_LEN_WIDTH-1:0]      target_read_burst_len,
  input  logic                            done_read,
  output logic                            start_write,
  output logic [ADDR_WIDTH-1:0]           target_write_addr,
  output logic [BURST_LEN_WIDTH-1:0]      target_write_burst_len,
  output logic [DATA_WIDTH-1:0]           target_write_data,
  output logic                            target_write_fifo_empty,
  input  logic                            target_write_fifo_pull,
  input  logic                            done_write
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           win_q, win_d;
  logic [IDX_W-1:0]           ptr_q, ptr_d;
  logic [IDX_W-1:0]           sel_idx;
  logic                       dir_q, dir_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic [NUM_REQ-1:0]         done_q, done_d;
  logic [NUM_REQ-1:0]         err_q, err_d;
  logic                       start_rd_q, start_rd_d;
  logic                       start_wr_q, start_wr_d;
  logic [ADDR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]      wr_addr_q, wr_addr_d;
  logic [BURST_LEN_WIDTH-1:0] rd_len_q, rd_len_d;
  logic [BURST_LEN_WIDTH-1:0] wr_len_q, wr_len_d;
  logic                       match_done;
  logic                       timeout;

  logic [ADDR_WIDTH-1:0]      addr_arr  [NUM_REQ];
  logic [BURST_LEN_WIDTH-1:0] len_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0]      wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]   = req_len[g*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First pending requester at or above ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    logic [SUM_W-1:0] cand;
    logic             found;
    sel_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = SUM_W'(ptr_q) + SUM_W'(j);
      if (cand >= SUM_W'(NUM_REQ)) cand = cand - SUM_W'(NUM_REQ);
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign match_done = dir_q ? done_write : done_read;
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    done_d     = '0;
    err_d      = '0;
    start_rd_d = start_rd_q;
    start_wr_d = start_wr_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    rd_len_d   = rd_len_q;
    wr_len_d   = wr_len_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          win_d          = sel_idx;
          dir_d          = req_write[sel_idx];
          gnt_d[sel_idx] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_BUSY;
          if (req_write[sel_idx]) begin
            start_wr_d = 1'b1;
            wr_addr_d  = addr_arr[sel_idx];
            wr_len_d   = len_arr[sel_idx];
          end else begin
            start_rd_d = 1'b1;
            rd_addr_d  = addr_arr[sel_idx];
            rd_len_d   = len_arr[sel_idx];
          end
        end
      end
      ST_BUSY: begin
        // A matching done on the last watchdog cycle still completes cleanly.
        if (match_done || timeout) begin
          start_rd_d    = 1'b0;
          start_wr_d    = 1'b0;
          rd_addr_d     = '0;
          wr_addr_d     = '0;
          rd_len_d      = '0;
          wr_len_d      = '0;
          done_d[win_q] = 1'b1;
          err_d[win_q]  = !match_done;
          ptr_d         = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_d       = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      ptr_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_len_q   <= '0;
      wr_len_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_rd_q <= start_rd_d;
      start_wr_q <= start_wr_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_len_q   <= rd_len_d;
      wr_len_q   <= wr_len_d;
    end
  end

  // Write-FIFO handshake passes straight through to the active write owner.
  always_comb begin
    req_wfifo_pull          = '0;
    target_write_data       = '0;
    target_write_fifo_empty = 1'b1;
    if (state_q == ST_BUSY && dir_q) begin
      target_write_data     = wdata_arr[win_q];
      target_write_fifo_empty = req_wfifo_empty[win_q];
      req_wfifo_pull[win_q] = target_write_fifo_pull;
    end
  end

  assign req_gnt                = gnt_q;
  assign req_done               = done_q;
  assign req_err                = err_q;
  assign start_read             = start_rd_q;
  assign start_write            = start_wr_q;
  assign target_read_addr       = rd_addr_q;
  assign target_read_burst_len  = rd_len_q;
  assign target_write_addr      = wr_addr_q;
  assign target_write_burst_len = wr_len_q;

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Self-checking bench for axi_req_arbiter: directed scenarios then random
// bursts against a transaction-level round-robin/timeout model.
module tb_axi_req_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write, req_wfifo_empty;
  logic [N-1:0]    req_wfifo_pull, req_gnt, req_done, req_err;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_wdata;
  logic            start_read, start_write, done_read, done_write;
  logic [AW-1:0]   target_read_addr, target_write_addr;
  logic [LW-1:0]   target_read_burst_len, target_write_burst_len;
  logic [DW-1:0]   target_write_data;
  logic            target_write_fifo_empty, target_write_fifo_pull;

  axi_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .DATA_WIDTH(DW), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_wfifo_empty(req_wfifo_empty),
    .req_wfifo_pull(req_wfifo_pull), .req_gnt(req_gnt), .req_done(req_done),
    .req_err(req_err), .start_read(start_read), .target_read_addr(target_read_addr),
    .target_read_burst_len(target_read_burst_len), .done_read(done_read),
    .start_write(start_write), .target_write_addr(target_write_addr),
    .target_write_burst_len(target_write_burst_len), .target_write_data(target_write_data),
    .target_write_fifo_empty(target_write_fifo_empty),
    .target_write_fifo_pull(target_write_fifo_pull), .done_write(done_write)
  );

  always #5 clk = ~clk;

  // Requester-side view of the world: pending requests and their payloads.
  bit            pend    [N];
  bit            m_dir   [N];
  logic [AW-1:0] m_addr  [N];
  logic [LW-1:0] m_len   [N];
  logic [DW-1:0] m_wdata [N];
  int            ptr;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]             = pend[i];
      req_write[i]             = m_dir[i];
      req_addr[i*AW +: AW]     = m_addr[i];
      req_len[i*LW +: LW]      = m_len[i];
      req_wdata[i*DW +: DW]    = m_wdata[i];
    end
  endtask

  function automatic int next_winner();
    for (int j = 0; j < int'(N); j++) begin
      if (pend[(ptr + j) % int'(N)]) return (ptr + j) % int'(N);
    end
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_start_read"},  64'(start_read), 64'(0));
    chk({tag, "_start_write"}, 64'(start_write), 64'(0));
    chk({tag, "_gnt"},         64'(req_gnt), 64'(0));
    chk({tag, "_done"},        64'(req_done), 64'(0));
    chk({tag, "_err"},         64'(req_err), 64'(0));
    chk({tag, "_rd_addr"},     64'(target_read_addr), 64'(0));
    chk({tag, "_rd_len"},      64'(target_read_burst_len), 64'(0));
    chk({tag, "_wr_addr"},     64'(target_write_addr), 64'(0));
    chk({tag, "_wr_len"},      64'(target_write_burst_len), 64'(0));
    chk({tag, "_wf_empty"},    64'(target_write_fifo_empty), 64'(1));
    chk({tag, "_wdata"},       64'(target_write_data), 64'(0));
    chk({tag, "_pull"},        64'(req_wfifo_pull), 64'(0));
  endtask

  // Called at a negedge with the arbiter idle; d = cycle (after grant) of the
  // matching done, wrong = also pulse the opposite done early.
  task automatic run_burst(input int d, input bit wrong, input bit keep);
    logic [N-1:0]  oh;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_len;
    int            w;
    bit            dir;
    bit            match;
    bit            other;
    drive_reqs();
    w        = next_winner();
    dir      = m_dir[w];
    oh       = '0;
    oh[w]    = 1'b1;
    exp_addr = m_addr[w];
    exp_len  = m_len[w];
    tick();
    chk("gnt", 64'(req_gnt), 64'(oh));
    chk("gnt_start_read", 64'(start_read), 64'(!dir));
    chk("gnt_start_write", 64'(start_write), 64'(dir));
    chk("gnt_rd_addr", 64'(target_read_addr), dir ? 64'(0) : 64'(exp_addr));
    chk("gnt_rd_len", 64'(target_read_burst_len), dir ? 64'(0) : 64'(exp_len));
    chk("gnt_wr_addr", 64'(target_write_addr), dir ? 64'(exp_addr) : 64'(0));
    chk("gnt_wr_len", 64'(target_write_burst_len), dir ? 64'(exp_len) : 64'(0));
    chk("gnt_done", 64'(req_done), 64'(0));
    if (!keep) begin
      pend[w] = 1'b0;
      drive_reqs();
    end
    for (int k = 1; k <= int'(T); k++) begin
      match = (k == d);
      other = wrong && (k == 1) && (d != 1);
      done_read  = dir ? other : match;
      done_write = dir ? match : other;
      target_write_fifo_pull = 1'($urandom_range(0, 1));
      req_wfifo_empty        = N'($urandom);
      #1;
      chk("route_wdata", 64'(target_write_data), dir ? 64'(m_wdata[w]) : 64'(0));
      chk("route_empty", 64'(target_write_fifo_empty), dir ? 64'(req_wfifo_empty[w]) : 64'(1));
      chk("route_pull", 64'(req_wfifo_pull),
          (dir && target_write_fifo_pull) ? 64'(oh) : 64'(0));
      tick();
      if (k == d || k == int'(T)) begin
        chk("cmpl_done", 64'(req_done), 64'(oh));
        chk("cmpl_err", 64'(req_err), (k == d) ? 64'(0) : 64'(oh));
        chk("cmpl_start_read", 64'(start_read), 64'(0));
        chk("cmpl_start_write", 64'(start_write), 64'(0));
        chk("cmpl_rd_addr", 64'(target_read_addr), 64'(0));
        chk("cmpl_wr_addr", 64'(target_write_addr), 64'(0));
        ptr = (w + 1) % int'(N);
        break;
      end else begin
        chk("busy_done", 64'(req_done), 64'(0));
        chk("busy_gnt", 64'(req_gnt), 64'(0));
        chk("busy_start_read", 64'(start_read), 64'(!dir));
        chk("busy_start_write", 64'(start_write), 64'(dir));
        chk("busy_addr", dir ? 64'(target_write_addr) : 64'(target_read_addr), 64'(exp_addr));
        chk("busy_len", dir ? 64'(target_write_burst_len) : 64'(target_read_burst_len),
            64'(exp_len));
      end
    end
    done_read  = 1'b0;
    done_write = 1'b0;
    target_write_fifo_pull = 1'b0;
    tick();
    check_quiet("gap");
  endtask

  task automatic set_req(input int i, input bit dir, input logic [AW-1:0] a, input logic [LW-1:0] l);
    pend[i]   = 1'b1;
    m_dir[i]  = dir;
    m_addr[i] = a;
    m_len[i]  = l;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ptr    = 0;
    rst    = 1'b1;
    done_read = 1'b0;
    done_write = 1'b0;
    target_write_fifo_pull = 1'b0;
    req_wfifo_empty = '1;
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b0;
      m_dir[i] = 1'b0;
      m_addr[i] = '0;
      m_len[i] = '0;
      m_wdata[i] = $urandom;
    end
    drive_reqs();
    tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Single read: addr 123, len 3, done_read 6 cycles after grant.
    set_req(0, 1'b0, 32'd123, 8'd3);
    run_burst(6, 1'b0, 1'b0);

    // A done while idle must be ignored.
    done_read = 1'b1;
    done_write = 1'b1;
    tick();
    done_read = 1'b0;
    done_write = 1'b0;
    tick();
    check_quiet("idle_done");

    // Bring the pointer back to 0 via requester 2.
    set_req(2, 1'b1, 32'h40, 8'd1);
    run_burst(2, 1'b0, 1'b0);

    // Contention with both held: 0,1,0,1.
    set_req(0, 1'b0, 32'h1000, 8'd7);
    set_req(1, 1'b0, 32'h2000, 8'd2);
    for (int r = 0; r < 4; r++) run_burst(3, 1'b0, 1'b1);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    drive_reqs();

    // Write routing for requester 1.
    m_wdata[1] = 32'hDEADBEEF;
    set_req(1, 1'b1, 32'd5, 8'd0);
    run_burst(4, 1'b0, 1'b0);

    // Opposite-direction done is ignored.
    set_req(0, 1'b0, 32'h3000, 8'd15);
    run_burst(5, 1'b1, 1'b0);

    // Matching done on the very last watchdog cycle is a normal completion.
    set_req(2, 1'b0, 32'h3100, 8'd1);
    run_burst(int'(T), 1'b0, 1'b0);

    // Silent master: watchdog abort, then a normal grant.
    set_req(0, 1'b0, 32'h5000, 8'd4);
    run_burst(1000, 1'b0, 1'b0);
    set_req(1, 1'b0, 32'h6000, 8'd1);
    run_burst(2, 1'b0, 1'b0);

    // Reset mid-burst: pointer now 2, so requester 2 wins first.
    set_req(2, 1'b0, 32'h7000, 8'd9);
    drive_reqs();
    tick();
    chk("pre_rst_gnt", 64'(req_gnt), 64'(3'b100));
    pend[2] = 1'b0;
    drive_reqs();
    tick();
    tick();
    #2 rst = 1'b1;
    #1 check_quiet("rst_mid");
    ptr = 0;
    tick();
    rst = 1'b0;
    tick();
    check_quiet("rst_after");
    set_req(1, 1'b0, 32'h8000, 8'd3);
    set_req(2, 1'b1, 32'h9000, 8'd5);
    run_burst(2, 1'b0, 1'b0);
    run_burst(3, 1'b0, 1'b0);

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      int  r;
      int  d;
      bit  any;
      any = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom, LW'($urandom));
          m_wdata[i] = $urandom;
        end
        any |= pend[i];
      end
      if (!any) set_req(it % int'(N), 1'($urandom_range(0, 1)), $urandom, LW'($urandom));
      r = $urandom_range(0, 9);
      d = (r == 0) ? int'(T) + 5 : (r == 1) ? int'(T) : $urandom_range(1, 8);
      run_burst(d, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
